// File: rtl/zvc_pkg.sv
// Shared types and defaults for the ZVC line scheduler: FSM state, default widths,
// and a constant clog2 helper for sizing counters and pointers.
package zvc_pkg;
  localparam int LIFM_W       = 1024;
  localparam int MT_W         = 3584;
  localparam int ZVC_PIPE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } zvc_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/zvc_sync_fifo.sv
// Synchronous FIFO with registered head data/valid; DEPTH must be a power of two.
// The caller keeps pushes away from a full FIFO.
module zvc_sync_fifo
  import zvc_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_nxt;
  logic [W-1:0]  head_nxt;
  logic          do_pop;

  assign do_pop = pop && valid;

  // Head register tracks the oldest entry; a push into an (about to be) empty FIFO bypasses mem.
  always_comb begin
    cnt_nxt  = count + CW'(push) - CW'(do_pop);
    head_nxt = dout;
    if (do_pop && count > CW'(1))                          head_nxt = mem[rd_ptr + AW'(1)];
    else if (push && (count == '0 || (do_pop && count == CW'(1)))) head_nxt = din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_nxt;
      dout  <= head_nxt;
      valid <= (cnt_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/zvc_line_scheduler.sv
// Issues job lines into the fixed-latency ZVC compressor and collects results in a
// credit-protected output FIFO. Optional stall/line counters under ZVC_SCHED_STATS_EN.
module zvc_line_scheduler
  import zvc_pkg::*;
#(
  parameter int LIFM_W     = zvc_pkg::LIFM_W,
  parameter int MT_W       = zvc_pkg::MT_W,
  parameter int PIPE_LAT   = zvc_pkg::ZVC_PIPE_LAT,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_lines,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIFM_W-1:0] in_lifm,
  input  logic [MT_W-1:0]   in_mt,
  output logic [LIFM_W-1:0] dp_lifm_line,
  output logic [MT_W-1:0]   dp_mt_line,
  input  logic [LIFM_W-1:0] dp_lifm_comp,
  input  logic [MT_W-1:0]   dp_mt_comp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIFM_W-1:0] out_lifm,
  output logic [MT_W-1:0]   out_mt
`ifdef ZVC_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  line_cnt
`endif
);
  localparam int FW = LIFM_W + MT_W;
  localparam int CW = clog2(FIFO_DEPTH + 1);
  localparam int IW = clog2(PIPE_LAT + 1);
  localparam int SW = CW + 1;

  zvc_state_e       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [PIPE_LAT:1] vld_pipe;
  logic [IW-1:0]    inflight_q;
  logic [CW-1:0]    fifo_count;
  logic [FW-1:0]    fifo_dout;
  logic             done_d, accept, push, pop;

  // Every line in flight already owns a FIFO slot, so a tag exit can never hit a full FIFO.
  assign in_ready     = (state_q == RUN) &&
                        (SW'(fifo_count) + SW'(inflight_q) < SW'(FIFO_DEPTH));
  assign accept       = in_valid && in_ready;
  assign push         = vld_pipe[PIPE_LAT];
  assign pop          = out_valid && out_ready;
  assign busy         = (state_q != IDLE);
  assign dp_lifm_line = accept ? in_lifm : '0;
  assign dp_mt_line   = accept ? in_mt   : '0;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (num_lines != '0) begin
          state_d     = RUN;
          remaining_d = num_lines;
        end else begin
          done_d = 1'b1;
        end
      end
      RUN: if (accept) begin
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) state_d = DRAIN;
      end
      // Leave as the last entry pops so done and busy-low land together the next cycle.
      DRAIN: if (inflight_q == '0 && fifo_count == CW'(pop)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      done        <= 1'b0;
      inflight_q  <= '0;
      vld_pipe    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done        <= done_d;
      inflight_q  <= inflight_q + IW'(accept) - IW'(push);
      vld_pipe[1] <= accept;
      for (int k = 2; k <= PIPE_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  zvc_sync_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     ({dp_lifm_comp, dp_mt_comp}),
    .dout    (fifo_dout),
    .valid   (out_valid),
    .count   (fifo_count)
  );

  assign {out_lifm, out_mt} = fifo_dout;

`ifdef ZVC_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      line_cnt  <= '0;
    end else if (state_q == IDLE && start) begin
      stall_cnt <= '0;
      line_cnt  <= '0;
    end else begin
      if (state_q == RUN && in_valid && !in_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (pop && line_cnt != '1) line_cnt <= line_cnt + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_zvc_line_scheduler.sv
// Bench for zvc_line_scheduler: queue-based model of accepted lines checked every cycle,
// plus directed jobs with hand-computed timing and count expectations.
module tb_zvc_line_scheduler;
  localparam int LW = 1024, MW = 3584, LAT = 2, DEPTH = 4, CNT_W = 16;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [CNT_W-1:0] num_lines = '0;
  logic in_ready, busy, done, out_valid;
  logic [LW-1:0] in_lifm = '0, dp_lifm_line, dp_lifm_comp, out_lifm;
  logic [MW-1:0] in_mt = '0, dp_mt_line, dp_mt_comp, out_mt;
`ifdef ZVC_SCHED_STATS_EN
  logic [CNT_W-1:0] stall_cnt, line_cnt;
`endif

  always #5 clk = ~clk;

  zvc_line_scheduler dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_lines(num_lines),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_lifm(in_lifm), .in_mt(in_mt), .dp_lifm_line(dp_lifm_line), .dp_mt_line(dp_mt_line),
    .dp_lifm_comp(dp_lifm_comp), .dp_mt_comp(dp_mt_comp),
`ifdef ZVC_SCHED_STATS_EN
    .stall_cnt(stall_cnt), .line_cnt(line_cnt),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_lifm(out_lifm), .out_mt(out_mt)
  );

  function automatic logic [LW-1:0] comp_l(input logic [LW-1:0] x);
    return {x[LW-2:0], x[LW-1]};
  endfunction
  function automatic logic [MW-1:0] comp_m(input logic [MW-1:0] x);
    return ~x;
  endfunction

  // Stand-in compressor: fixed LAT-cycle datapath reset together with the scheduler.
  logic [LW-1:0] cl1, cl2;
  logic [MW-1:0] cm1, cm2;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cl1 <= '0; cl2 <= '0; cm1 <= '0; cm2 <= '0;
    end else begin
      cl1 <= comp_l(dp_lifm_line); cl2 <= cl1;
      cm1 <= comp_m(dp_mt_line);   cm2 <= cm1;
    end
  end
  assign dp_lifm_comp = cl2;
  assign dp_mt_comp   = cm2;

  int checks = 0, passes = 0;
  task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  typedef struct { logic [LW-1:0] l; logic [MW-1:0] m; int avail; } exp_t;
  exp_t q[$];
  int   cyc = 0, to_accept = 0, outstanding = 0;
  bit   m_busy = 0, m_done = 0;
  int   acc_total = 0, done_seen = 0, start_cyc = -1, done_cyc = -1;
  int   pop_cyc[$];

  // Model: a job accepts while lines remain and outstanding (accepted, not popped) < DEPTH;
  // each accepted line is poppable LAT+1 cycles later, in order.
  always @(negedge clk) begin : model
    bit e_rdy, e_ov, acc, pp, nd;
    logic [LW-1:0] el;
    logic [MW-1:0] em;
    if (!reset_n) begin
      q.delete(); to_accept = 0; outstanding = 0; m_busy = 0; m_done = 0;
      chk("rst_in_ready", in_ready === 1'b0, 64'(in_ready), 0);
      chk("rst_out_valid", out_valid === 1'b0, 64'(out_valid), 0);
      chk("rst_busy", busy === 1'b0, 64'(busy), 0);
      chk("rst_done", done === 1'b0, 64'(done), 0);
      chk("rst_dp", dp_lifm_line === '0 && dp_mt_line === '0, dp_mt_line[63:0], 0);
      chk("rst_out_data", out_lifm === '0 && out_mt === '0, out_mt[63:0], 0);
    end else begin
      e_rdy = m_busy && to_accept > 0 && outstanding < DEPTH;
      e_ov  = q.size() > 0 && q[0].avail <= cyc;
      acc   = in_valid && e_rdy;
      pp    = e_ov && out_ready;
      el    = acc ? in_lifm : '0;
      em    = acc ? in_mt   : '0;
      chk("busy", busy === m_busy, 64'(busy), 64'(m_busy));
      chk("done", done === m_done, 64'(done), 64'(m_done));
      chk("in_ready", in_ready === e_rdy, 64'(in_ready), 64'(e_rdy));
      chk("out_valid", out_valid === e_ov, 64'(out_valid), 64'(e_ov));
      chk("dp_lifm_line", dp_lifm_line === el, dp_lifm_line[63:0], el[63:0]);
      chk("dp_mt_line", dp_mt_line === em, dp_mt_line[63:0], em[63:0]);
      if (e_ov) begin
        chk("out_lifm", out_lifm === q[0].l, out_lifm[63:0], q[0].l[63:0]);
        chk("out_mt", out_mt === q[0].m, out_mt[63:0], q[0].m[63:0]);
      end
      if (done === 1'b1) begin done_seen++; done_cyc = cyc; end
      nd = 0;
      if (acc) begin
        q.push_back('{comp_l(in_lifm), comp_m(in_mt), cyc + LAT + 1});
        to_accept--; outstanding++; acc_total++;
      end
      if (pp) begin q.delete(0); outstanding--; pop_cyc.push_back(cyc); end
      if (m_busy) begin
        if (to_accept == 0 && outstanding == 0) begin m_busy = 0; nd = 1; end
      end else if (start) begin
        start_cyc = cyc;
        if (num_lines != 0) begin m_busy = 1; to_accept = int'(num_lines); end
        else nd = 1;
      end
      m_done = nd;
    end
    cyc++;
  end

  logic [31:0] seq = 0;
  task automatic step();
    @(posedge clk); #1;
    seq++;
    in_lifm = {32{seq}};
    in_mt   = {112{seq ^ 32'hC3C3_0000}};
  endtask

  task automatic start_job(input int n);
    start = 1'b1; num_lines = CNT_W'(n);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int d0 = done_seen;
    int k  = 0;
    while (done_seen == d0 && k < 300) begin step(); k++; end
    chk(nm, done_seen != d0, 64'(k), 300);
  endtask

  // Three lines, free-flowing: pops at s+4..s+6, done at s+7.
  task automatic basic_job(input string tg);
    int s;
    pop_cyc.delete();
    in_valid = 1'b1; out_ready = 1'b1;
    start_job(3);
    wait_done({tg, "_done_seen"});
    s = start_cyc;
    chk({tg, "_pops"}, pop_cyc.size() == 3, 64'(pop_cyc.size()), 3);
    for (int i = 0; i < 3; i++)
      if (i < pop_cyc.size())
        chk({tg, "_pop_cyc"}, pop_cyc[i] == s + 4 + i, 64'(pop_cyc[i] - s), 64'(4 + i));
    chk({tg, "_done_cyc"}, done_cyc == s + 7, 64'(done_cyc - s), 7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int a0, d0;
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    basic_job("t1");

    // Backpressure: only DEPTH lines accepted until the FIFO drains.
    pop_cyc.delete();
    in_valid = 1'b1; out_ready = 1'b0; a0 = acc_total;
    start_job(8);
    repeat (10) step();
    chk("t2_acc_stalled", acc_total - a0 == 4, 64'(acc_total - a0), 4);
    chk("t2_in_ready_low", in_ready === 1'b0, 64'(in_ready), 0);
    out_ready = 1'b1;
    wait_done("t2_done_seen");
    chk("t2_pops", pop_cyc.size() == 8, 64'(pop_cyc.size()), 8);

    // Zero-length job.
    a0 = acc_total;
    start_job(0);
    @(negedge clk);
    chk("t3_done", done === 1'b1, 64'(done), 1);
    chk("t3_busy", busy === 1'b0, 64'(busy), 0);
    step();
    chk("t3_done_cyc", done_cyc == start_cyc + 1, 64'(done_cyc - start_cyc), 1);
    repeat (2) step();
    chk("t3_no_accept", acc_total == a0, 64'(acc_total - a0), 0);

    // Start while busy is ignored.
    in_valid = 1'b1; out_ready = 1'b1; a0 = acc_total;
    start_job(3);
    step();
    start = 1'b1; num_lines = 16'd5;
    step();
    start = 1'b0;
    wait_done("t4_done_seen");
    repeat (4) step();
    chk("t4_accepts", acc_total - a0 == 3, 64'(acc_total - a0), 3);

    // Reset with two lines in flight during DRAIN.
    d0 = done_seen;
    start_job(2);
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("t5_busy", busy === 1'b0, 64'(busy), 0);
    chk("t5_in_ready", in_ready === 1'b0, 64'(in_ready), 0);
    chk("t5_out_valid", out_valid === 1'b0, 64'(out_valid), 0);
    chk("t5_dp_mt", dp_mt_line === '0, dp_mt_line[63:0], 0);
    step(); step();
    reset_n = 1'b1;
    repeat (6) step();
    chk("t5_no_done", done_seen == d0, 64'(done_seen - d0), 0);
    basic_job("t5b");

    // Bubble: in_valid 1,0,1 across RUN.
    pop_cyc.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    start_job(2);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_gap_mt", dp_mt_line === '0, dp_mt_line[63:0], 0);
    chk("t6_gap_lifm", dp_lifm_line === '0, dp_lifm_line[63:0], 0);
    step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done("t6_done_seen");
    chk("t6_pops", pop_cyc.size() == 2, 64'(pop_cyc.size()), 2);

    repeat (3) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/zvc_line_scheduler.md
# zvc_line_scheduler

Sequencing controller for the zero-value compressor (ZVC) datapath. It accepts a job of N lowered-IFM/mapping-table line pairs from an upstream line source and issues them into the fixed-latency, non-stallable compressor pipeline. Each in-flight line is tracked with a valid tag, and results land in a credit-protected output FIFO so downstream backpressure never drops a compressed line. It sits between the line fetch unit and the compressed-line writer.

## Interface
- LIFM_W, 1024: lowered-IFM line width (LINE_SIZE*WORD_WIDTH).
- MT_W, 3584: mapping-table line width (LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ).
- PIPE_LAT, 2: compressor datapath latency in cycles.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥ PIPE_LAT+1.
- CNT_W, 16: job line-count width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low, also drives the compressor datapath reset.
- start  in  1  job start pulse; sampled only in IDLE.
- num_lines  in  CNT_W  lines in the job; sampled with start.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the job completes.
- in_valid / in_ready  in / out  1  upstream line handshake.
- in_lifm / in_mt  in  LIFM_W / MT_W  upstream line.
- dp_lifm_line / dp_mt_line  out  LIFM_W / MT_W  to compressor inputs.
- dp_lifm_comp / dp_mt_comp  in  LIFM_W / MT_W  from compressor outputs.
- out_valid / out_ready  out / in  1  downstream handshake.
- out_lifm / out_mt  out  LIFM_W / MT_W  compressed line.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN: on start with num_lines≠0. Latch remaining=num_lines.
  - IDLE→IDLE: on start with num_lines=0. done pulses the next cycle.
  - RUN→DRAIN: on the accept of the last line (remaining reaches 0).
  - DRAIN→IDLE: when inflight==0, FIFO empty and no push is pending. done pulses for exactly one cycle on that transition.
- start is ignored outside IDLE.
- Credit rule: in_ready = (state==RUN) && (fifo_count + inflight < FIFO_DEPTH). It depends only on registered state, never on in_valid.
- Accept = in_valid && in_ready.
  - dp_lifm_line and dp_mt_line equal in_lifm/in_mt when accept is high; otherwise they are all zeros. An all-zero mt yields an all-zero mask, i.e. a bubble.
  - Accept shifts a 1 into a PIPE_LAT-deep tag shift register; non-accept cycles shift in a 0.
- Tag exit: when the tag at PIPE_LAT is 1, {dp_lifm_comp, dp_mt_comp} is pushed into the FIFO that same cycle. The credit rule guarantees the push is never to a full FIFO.
- inflight = popcount of the tag register, maintained as a counter: +accept, −tag exit.
- Pop = out_valid && out_ready.
- Simultaneous push and pop: fifo_count stays the same; both operations take effect.
- Simultaneous accept and tag exit: inflight stays the same.
- Reset mid-job: FSM returns to IDLE, tags clear, FIFO empties, counters clear. No done pulse is generated.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, done=0, dp_* = 0, out_lifm/out_mt = 0.
- Latency: accept in cycle t → datapath result valid in cycle t+PIPE_LAT → push at the end of t+PIPE_LAT → out_valid high in cycle t+PIPE_LAT+1 (3 with defaults), given an empty FIFO.
- Throughput: 1 line/cycle when out_ready is held high.
- With out_ready low, at most FIFO_DEPTH lines are accepted, then in_ready drops.
- busy rises the cycle after start. done rises the cycle after the last pop, and busy falls in the same cycle.
- out_valid and out data are registered FIFO outputs. Data holds stable while out_valid && !out_ready.

## Configuration
- ZVC_SCHED_STATS_EN: when defined, adds two outputs, both cleared on start and saturating:
  - stall_cnt (CNT_W): counts RUN cycles with in_valid && !in_ready.
  - line_cnt (CNT_W): counts pops.
- When ZVC_SCHED_STATS_EN is undefined, these ports and counters do not exist and the block behaviour is otherwise identical.

## Structure
- Shared package zvc_pkg:
  - FSM state enum (IDLE/RUN/DRAIN).
  - Default width constants LIFM_W, MT_W, ZVC_PIPE_LAT.
  - Helper function clog2 for counter widths.
- One sub-module, zvc_sync_fifo: parameterized width and depth, registered outputs, push/pop/count, same async reset.
- FSM, tag shift register and credit logic stay in the top level.

## Test plan
- Basic job: num_lines=3, in_valid and out_ready always high → 3 outputs in cycles t+3, t+4, t+5 matching the compressor outputs; done 1 cycle after the last pop.
- Backpressure: num_lines=8, out_ready=0 → exactly 4 accepts, then in_ready=0. Raising out_ready → all 8 delivered in order with none lost.
- Zero-length job: start with num_lines=0 → done pulses the next cycle, busy stays 0, in_ready stays 0.
- Start while busy: second start mid-job with num_lines=5 → ignored; only the first job's lines are accepted.
- Reset mid-DRAIN: assert reset_n=0 with 2 lines in flight → all outputs return to reset values immediately, no done pulse. A new job afterwards behaves as the basic job.
- Bubble insertion: in_valid toggling 1,0,1 → dp_mt_line is 0 in the gap cycle, and exactly 2 outputs are produced.
